alu_operand_seq: RTL and testbench

Front-end sequencer that drives the operand and opcode inputs of the 4-bit sign-magnitude ALU from a 4-switch bank and two push buttons. The user enters A, then B, then the opcode, one debounced ENTER press per step. The block then presents the stable operand set to the ALU and captures its result and flags. The captured result is held for display until the next sequence starts.

---
 rtl/alu_operand_seq.sv | 166 ++++++++++++++++
 tb/tb_alu_operand_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_seq.sv
// Operand/opcode entry sequencer for the 4-bit sign-magnitude ALU.
// Two debounced buttons step a small FSM that latches A, B, opcode, then captures the ALU result.

module alu_operand_seq_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press_c
);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_deb;
  logic             r_deb_d;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_deb_d <= r_deb;
      if (r_sync[1] != r_deb) begin
        if (w_cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
          r_deb <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press_c = r_deb & ~r_deb_d;

endmodule

module alu_operand_seq #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_sw,
  input  logic       i_btn_enter,
  input  logic       i_btn_clear,
  input  logic [3:0] i_alu_led,
  input  logic       i_alu_carry,
  input  logic       i_alu_overflow,
  output logic [3:0] o_a,
  output logic [3:0] o_b,
  output logic [2:0] o_op,
  output logic [3:0] o_res,
  output logic       o_carry,
  output logic       o_overflow,
  output logic       o_done,
  output logic [2:0] o_step
);

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_EVAL   = 3'd3,
    S_SHOW   = 3'd4
  } state_t;

  state_t r_state;
  logic   w_enter;
  logic   w_clear;

  alu_operand_seq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_enter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_btn    (i_btn_enter),
    .o_press_c(w_enter)
  );

  alu_operand_seq_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_clear (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_btn    (i_btn_clear),
    .o_press_c(w_clear)
  );

  // Clear has priority over enter; EVAL never consumes an enter pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_GET_A;
      o_a        <= 4'd0;
      o_b        <= 4'd0;
      o_op       <= 3'd0;
      o_res      <= 4'd0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_done     <= 1'b0;
    end else if (w_clear) begin
      r_state    <= S_GET_A;
      o_a        <= 4'd0;
      o_b        <= 4'd0;
      o_op       <= 3'd0;
      o_res      <= 4'd0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (r_state)
        S_GET_A: if (w_enter) begin
          o_a     <= i_sw;
          r_state <= S_GET_B;
        end
        S_GET_B: if (w_enter) begin
          o_b     <= i_sw;
          r_state <= S_GET_OP;
        end
        S_GET_OP: if (w_enter) begin
          o_op    <= i_sw[2:0];
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          o_res      <= i_alu_led;
          o_carry    <= i_alu_carry;
          o_overflow <= i_alu_overflow;
          o_done     <= 1'b1;
          r_state    <= S_SHOW;
        end
        S_SHOW: if (w_enter) begin
          o_res      <= 4'd0;
          o_carry    <= 1'b0;
          o_overflow <= 1'b0;
          o_done     <= 1'b0;
          r_state    <= S_GET_A;
        end
        default: r_state <= S_GET_A;
      endcase
    end
  end

  always_comb begin
    o_step = 3'b000;
    case (r_state)
      S_GET_A:  o_step = 3'b001;
      S_GET_B:  o_step = 3'b010;
      S_GET_OP: o_step = 3'b100;
      default:  o_step = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq with a short debounce window.

module tb_alu_operand_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'd0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] alu_led = 4'd0;
  logic       alu_carry = 1'b0;
  logic       alu_overflow = 1'b0;
  logic [3:0] a, b, res;
  logic [2:0] op, step;
  logic       carry, overflow, done;

  int n_vec = 0;
  int n_err = 0;

  alu_operand_seq #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sw          (sw),
    .i_btn_enter   (btn_enter),
    .i_btn_clear   (btn_clear),
    .i_alu_led     (alu_led),
    .i_alu_carry   (alu_carry),
    .i_alu_overflow(alu_overflow),
    .o_a           (a),
    .o_b           (b),
    .o_op          (op),
    .o_res         (res),
    .o_carry       (carry),
    .o_overflow    (overflow),
    .o_done        (done),
    .o_step        (step)
  );

  always #5 clk = ~clk;

  task automatic wait_step(input logic [2:0] exp, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (step === exp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_all();
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic press_enter(input logic [3:0] v, input logic [2:0] exp, output bit ok);
    sw = v;
    btn_enter = 1'b1;
    wait_step(exp, ok);
    release_all();
  endtask

  task automatic test_reset();
    n_vec++; if (step !== 3'b001) begin n_err++; $display("FAIL reset_step got %b want 001", step); end
    n_vec++; if ({a, b, op, res, carry, overflow, done} !== 19'd0) begin n_err++;
      $display("FAIL reset_outs got %h want 0", {a, b, op, res, carry, overflow, done}); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (step !== 3'b001) begin n_err++; $display("FAIL post_reset_step got %b want 001", step); end
  endtask

  task automatic test_glitch();
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    n_vec++; if (step !== 3'b001) begin n_err++; $display("FAIL glitch_step got %b want 001", step); end
    n_vec++; if (a !== 4'd0) begin n_err++; $display("FAIL glitch_a got %b want 0000", a); end
  endtask

  task automatic test_operand_seq();
    bit ok;
    alu_led = 4'b0101; alu_carry = 1'b0; alu_overflow = 1'b0;
    press_enter(4'b0011, 3'b010, ok);
    n_vec++; if (!ok || a !== 4'b0011) begin n_err++; $display("FAIL seq_a got %b step %b want 0011 010", a, step); end
    press_enter(4'b0010, 3'b100, ok);
    n_vec++; if (!ok || b !== 4'b0010) begin n_err++; $display("FAIL seq_b got %b step %b want 0010 100", b, step); end
    sw = 4'b0000; btn_enter = 1'b1;
    wait_step(3'b000, ok);
    n_vec++; if (!ok || op !== 3'b000 || done !== 1'b0) begin n_err++;
      $display("FAIL seq_eval op %b done %b step %b want 000 0 000", op, done, step); end
    @(negedge clk);
    n_vec++; if (res !== 4'b0101 || done !== 1'b1 || step !== 3'b000 || carry !== 1'b0) begin n_err++;
      $display("FAIL seq_show res %b done %b step %b want 0101 1 000", res, done, step); end
    release_all();
    n_vec++; if (done !== 1'b1 || a !== 4'b0011 || b !== 4'b0010) begin n_err++;
      $display("FAIL seq_hold done %b a %b b %b want 1 0011 0010", done, a, b); end
    press_enter(4'b1111, 3'b001, ok);
    n_vec++; if (!ok || done !== 1'b0 || res !== 4'd0 || a !== 4'b0011) begin n_err++;
      $display("FAIL seq_restart done %b res %b a %b want 0 0000 0011", done, res, a); end
  endtask

  task automatic test_overflow();
    bit ok;
    alu_led = 4'b0000; alu_carry = 1'b1; alu_overflow = 1'b1;
    press_enter(4'b0111, 3'b010, ok);
    press_enter(4'b0111, 3'b100, ok);
    press_enter(4'b0001, 3'b000, ok);
    n_vec++; if (!ok || overflow !== 1'b1 || res !== 4'b0000 || carry !== 1'b1 || done !== 1'b1) begin n_err++;
      $display("FAIL ovf_capture ovf %b res %b carry %b done %b want 1 0000 1 1", overflow, res, carry, done); end
    n_vec++; if (op !== 3'b001) begin n_err++; $display("FAIL ovf_op got %b want 001", op); end
    press_enter(4'b0000, 3'b001, ok);
    n_vec++; if (!ok || done !== 1'b0 || overflow !== 1'b0 || step !== 3'b001) begin n_err++;
      $display("FAIL ovf_next done %b ovf %b step %b want 0 0 001", done, overflow, step); end
  endtask

  task automatic test_hold();
    bit ok;
    sw = 4'b1010; btn_enter = 1'b1;
    repeat (50) @(negedge clk);
    n_vec++; if (step !== 3'b010 || a !== 4'b1010) begin n_err++;
      $display("FAIL hold_once step %b a %b want 010 1010", step, a); end
    release_all();
    n_vec++; if (step !== 3'b010) begin n_err++; $display("FAIL hold_release step %b want 010", step); end
    press_enter(4'b0101, 3'b100, ok);
    n_vec++; if (!ok || b !== 4'b0101) begin n_err++; $display("FAIL hold_second b %b step %b want 0101 100", b, step); end
  endtask

  task automatic test_clear();
    bit ok;
    btn_clear = 1'b1; wait_step(3'b001, ok); release_all();
    n_vec++; if (!ok) begin n_err++; $display("FAIL clear_first step %b want 001", step); end
    press_enter(4'b0110, 3'b010, ok);
    press_enter(4'b1001, 3'b100, ok);
    n_vec++; if (!ok || a !== 4'b0110 || b !== 4'b1001) begin n_err++;
      $display("FAIL clear_setup a %b b %b want 0110 1001", a, b); end
    btn_clear = 1'b1; wait_step(3'b001, ok); release_all();
    n_vec++; if (!ok || {a, b, op, res, carry, overflow, done} !== 19'd0) begin n_err++;
      $display("FAIL clear_getop outs %h step %b want 0 001", {a, b, op, res, carry, overflow, done}, step); end
    press_enter(4'b0101, 3'b010, ok);
    sw = 4'b1110; btn_enter = 1'b1; btn_clear = 1'b1;
    wait_step(3'b001, ok);
    repeat (5) @(negedge clk);
    n_vec++; if (!ok || step !== 3'b001 || a !== 4'd0 || b !== 4'd0) begin n_err++;
      $display("FAIL clear_enter step %b a %b b %b want 001 0000 0000", step, a, b); end
    release_all();
  endtask

  task automatic test_async_reset();
    bit ok;
    alu_led = 4'b1000; alu_carry = 1'b1; alu_overflow = 1'b0;
    press_enter(4'b0111, 3'b010, ok);
    press_enter(4'b0001, 3'b100, ok);
    press_enter(4'b0010, 3'b000, ok);
    n_vec++; if (!ok || done !== 1'b1 || res !== 4'b1000) begin n_err++;
      $display("FAIL rst_setup done %b res %b want 1 1000", done, res); end
    @(posedge clk); #2 rst_n = 1'b0;
    #2;
    n_vec++; if ({a, b, op, res, carry, overflow, done} !== 19'd0 || step !== 3'b001) begin n_err++;
      $display("FAIL rst_async outs %h step %b want 0 001", {a, b, op, res, carry, overflow, done}, step); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    press_enter(4'b1100, 3'b010, ok);
    n_vec++; if (!ok || a !== 4'b1100) begin n_err++; $display("FAIL rst_after a %b step %b want 1100 010", a, step); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_glitch();
    test_operand_seq();
    test_overflow();
    test_hold();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
